// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin two-port arbiter and burst sequencer for a single-ported combinational-read ROM
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   m0_req/m0_addr/m0_len     fetch port request, start address, burst length minus 1
//   m0_gnt/m0_rvalid/m0_rdata/m0_rlast  fetch port grant pulse and registered response
//   m1_req/m1_addr            data/debug port single-beat request and address
//   m1_gnt/m1_rvalid/m1_rdata data/debug port grant pulse and registered response
//   rom_addr/rom_data         ROM address out, combinational ROM data in
//   busy                      fetch burst in progress
module rom_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [1:0]        m0_len,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rlast,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t            state;
    logic              last_gnt;
    logic [1:0]        cnt;
    logic [1:0]        len;
    logic [ADDR_W-1:0] base;
    logic              idle;
    // last_gnt holds the port granted most recently; on a tie the other port wins
    assign idle     = state == IDLE && !rst;
    assign m0_gnt   = idle && m0_req && (!m1_req || last_gnt);
    assign m1_gnt   = idle && m1_req && (!m0_req || !last_gnt);
    assign busy     = state == BURST;
    // burst addresses wrap naturally at the ROM depth
    assign rom_addr = rst ? '0 : busy ? base + ADDR_W'(cnt) : m1_gnt ? m1_addr : m0_addr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            cnt       <= '0;
            len       <= '0;
            base      <= '0;
            m0_rvalid <= 1'b0;
            m0_rlast  <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt || busy;
            m0_rlast  <= m0_gnt ? m0_len == 2'd0 : busy && cnt == len;
            if (m0_gnt || busy) m0_rdata <= rom_data;
            m1_rvalid <= m1_gnt;
            if (m1_gnt) m1_rdata <= rom_data;
            if (m0_gnt || m1_gnt) last_gnt <= m1_gnt;
            if (m0_gnt && m0_len != 2'd0) begin
                state <= BURST;
                base  <= m0_addr;
                len   <= m0_len;
                cnt   <= 2'd1;
            end else if (busy) begin
                state <= cnt == len ? IDLE : BURST;
                cnt   <= cnt == len ? 2'd0 : cnt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: self-checking bench for rom_arbiter with directed scenarios and a queue-based reference model
module tb_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [9:0]  m0_addr = '0, m1_addr = '0, rom_addr;
    logic [1:0]  m0_len = '0;
    logic        m0_gnt, m0_rvalid, m0_rlast, m1_gnt, m1_rvalid, busy;
    logic [31:0] m0_rdata, m1_rdata, rom_data;
    logic [31:0] rom [1024];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    rom_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_len(m0_len), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    // Reference model: each accepted request schedules its response beats on absolute cycle numbers
    typedef struct {int c; logic [31:0] d; logic l;} beat_t;
    beat_t       q0[$], q1[$];
    int          cyc, free_at, last_port;
    logic        e_g0, e_g1, e_v0, e_v1, e_l0, e_busy;
    logic [31:0] e_d0, e_d1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        rst = 1'b0;
        cyc = 0;
        free_at = 0;
        last_port = 1;
        q0.delete();
        q1.delete();
        e_d0 = '0;
        e_d1 = '0;
    endtask

    task automatic model_step();
        int    winner;
        beat_t b;
        e_busy = cyc < free_at;
        winner = -1;
        if (!e_busy) begin
            if (m0_req && m1_req) winner = last_port == 0 ? 1 : 0;
            else if (m0_req) winner = 0;
            else if (m1_req) winner = 1;
        end
        e_g0 = winner == 0;
        e_g1 = winner == 1;
        if (winner == 0) begin
            for (int i = 0; i <= int'(m0_len); i++)
                q0.push_back('{cyc + 1 + i, rom[(int'(m0_addr) + i) % 1024], i == int'(m0_len)});
            free_at = cyc + int'(m0_len) + 1;
            last_port = 0;
        end else if (winner == 1) begin
            q1.push_back('{cyc + 1, rom[m1_addr], 1'b1});
            free_at = cyc + 1;
            last_port = 1;
        end
        e_v0 = 1'b0;
        e_l0 = 1'b0;
        e_v1 = 1'b0;
        if (q0.size() > 0 && q0[0].c == cyc) begin
            b = q0.pop_front();
            e_v0 = 1'b1;
            e_d0 = b.d;
            e_l0 = b.l;
        end
        if (q1.size() > 0 && q1[0].c == cyc) begin
            b = q1.pop_front();
            e_v1 = 1'b1;
            e_d1 = b.d;
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1;
        m1_req = 1'b1;
        m0_addr = 10'h005;
        @(negedge clk);
        checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rlast, busy} !== 6'b0) begin failures++; $display("FAIL reset_ctrl: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rlast, busy}); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
        checks++; if (rom_addr !== 10'h000) begin failures++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        step();
        m0_req = 1'b1; m0_addr = 10'h005; m0_len = 2'd0;
        #2;
        checks++; if ({m0_gnt, m1_gnt, busy} !== 3'b100) begin failures++; $display("FAIL single_gnt: got %b want 100", {m0_gnt, m1_gnt, busy}); end
        checks++; if (rom_addr !== 10'h005) begin failures++; $display("FAIL single_rom_addr: got %h want 005", rom_addr); end
        step();
        m0_req = 1'b0;
        #2;
        checks++; if ({m0_rvalid, m0_rlast, busy, m1_rvalid} !== 4'b1100) begin failures++; $display("FAIL single_resp: got %b want 1100", {m0_rvalid, m0_rlast, busy, m1_rvalid}); end
        checks++; if (m0_rdata !== rom[5]) begin failures++; $display("FAIL single_rdata: got %h want %h", m0_rdata, rom[5]); end
        step();
        #2;
        checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL single_extra_rvalid: got %b want 0", m0_rvalid); end
    endtask

    task automatic test_burst();
        logic [9:0] exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        int busy_n = 0;
        do_reset();
        step();
        m0_req = 1'b1; m0_addr = 10'h3FE; m0_len = 2'd3;
        #2;
        checks++; if ({m0_gnt, busy, rom_addr} !== {2'b10, exp_a[0]}) begin failures++; $display("FAIL burst_start: gnt/busy/addr got %b %b %h want 1 0 %h", m0_gnt, busy, rom_addr, exp_a[0]); end
        for (int i = 1; i <= 4; i++) begin
            step();
            m0_req = 1'b0;
            #2;
            busy_n += int'(busy);
            if (i < 4) begin
                checks++; if (rom_addr !== exp_a[i]) begin failures++; $display("FAIL burst_addr beat %0d: got %h want %h", i, rom_addr, exp_a[i]); end
            end
            checks++; if ({m0_rvalid, m0_rlast} !== {1'b1, i == 4}) begin failures++; $display("FAIL burst_valid beat %0d: got %b want %b", i, {m0_rvalid, m0_rlast}, {1'b1, i == 4}); end
            checks++; if (m0_rdata !== rom[exp_a[i-1]]) begin failures++; $display("FAIL burst_rdata beat %0d: got %h want %h", i, m0_rdata, rom[exp_a[i-1]]); end
        end
        checks++; if (busy_n !== 3) begin failures++; $display("FAIL burst_busy_cycles: got %0d want 3", busy_n); end
        step();
        #2;
        checks++; if ({m0_rvalid, busy} !== 2'b00) begin failures++; $display("FAIL burst_after: got %b want 00", {m0_rvalid, busy}); end
    endtask

    task automatic test_alternate();
        logic [9:0] ga, ga_prev;
        do_reset();
        m0_len = 2'd0;
        m0_addr = 10'($urandom);
        m1_addr = 10'($urandom);
        ga = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            m0_req = 1'b1;
            m1_req = 1'b1;
            if (k % 2 == 1) m0_addr = 10'($urandom);
            if (k > 0 && k % 2 == 0) m1_addr = 10'($urandom);
            #2;
            ga_prev = ga;
            ga = (k % 2 == 0) ? m0_addr : m1_addr;
            checks++; if ({m0_gnt, m1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL alt_gnt cycle %0d: got %b want %b", k, {m0_gnt, m1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            if (k > 0) begin
                checks++; if ({m0_rvalid, m1_rvalid} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL alt_rvalid cycle %0d: got %b want %b", k, {m0_rvalid, m1_rvalid}, (k % 2 == 1) ? 2'b10 : 2'b01); end
                checks++; if (((k % 2 == 1) ? m0_rdata : m1_rdata) !== rom[ga_prev]) begin failures++; $display("FAIL alt_rdata cycle %0d: got %h want %h", k, (k % 2 == 1) ? m0_rdata : m1_rdata, rom[ga_prev]); end
            end
        end
        step();
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_m1_during_burst();
        logic [9:0] x;
        do_reset();
        step();
        m0_req = 1'b1; m0_addr = 10'($urandom); m0_len = 2'd2; m1_req = 1'b0;
        #2;
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL mb_m0_gnt: got %b want 1", m0_gnt); end
        x = 10'($urandom);
        for (int i = 1; i <= 2; i++) begin
            step();
            m0_req = 1'b0; m1_req = 1'b1; m1_addr = x;
            #2;
            checks++; if ({m1_gnt, busy} !== 2'b01) begin failures++; $display("FAIL mb_withheld cycle %0d: gnt/busy got %b want 01", i, {m1_gnt, busy}); end
        end
        step();
        #2;
        checks++; if ({m1_gnt, busy, m0_rvalid, m0_rlast} !== 4'b1011) begin failures++; $display("FAIL mb_m1_gnt: got %b want 1011", {m1_gnt, busy, m0_rvalid, m0_rlast}); end
        checks++; if (rom_addr !== x) begin failures++; $display("FAIL mb_rom_addr: got %h want %h", rom_addr, x); end
        step();
        m1_req = 1'b0;
        #2;
        checks++; if ({m1_rvalid, m1_rdata} !== {1'b1, rom[x]}) begin failures++; $display("FAIL mb_m1_resp: got %b %h want 1 %h", m1_rvalid, m1_rdata, rom[x]); end
    endtask

    task automatic test_reset_mid_burst();
        logic [9:0] a;
        do_reset();
        step();
        m0_req = 1'b1; m0_addr = 10'($urandom); m0_len = 2'd3;
        #2;
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rmb_gnt: got %b want 1", m0_gnt); end
        step();
        m0_req = 1'b0;
        #2;
        checks++; if ({busy, m0_rvalid} !== 2'b11) begin failures++; $display("FAIL rmb_beat1: got %b want 11", {busy, m0_rvalid}); end
        #1 rst = 1'b1;
        #1;
        checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rlast, busy} !== 6'b0) begin failures++; $display("FAIL rmb_async_ctrl: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rlast, busy}); end
        checks++; if ({m0_rdata, rom_addr} !== 42'h0) begin failures++; $display("FAIL rmb_async_data: rdata %h addr %h want 0 0", m0_rdata, rom_addr); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            #2;
            checks++; if ({m0_rvalid, m0_rlast, busy} !== 3'b000) begin failures++; $display("FAIL rmb_stray cycle %0d: got %b want 000", i, {m0_rvalid, m0_rlast, busy}); end
        end
        step();
        a = 10'($urandom);
        m0_req = 1'b1; m0_addr = a; m0_len = 2'd0;
        #2;
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rmb_regnt: got %b want 1", m0_gnt); end
        step();
        m0_req = 1'b0;
        #2;
        checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, rom[a]}) begin failures++; $display("FAIL rmb_resp: got %b %h want 1 %h", m0_rvalid, m0_rdata, rom[a]); end
    endtask

    task automatic test_idle();
        logic [9:0] a, b;
        do_reset();
        a = 10'($urandom);
        b = 10'($urandom);
        step();
        m0_req = 1'b1; m0_addr = a; m0_len = 2'd0;
        #2;
        step();
        m0_req = 1'b0; m1_req = 1'b1; m1_addr = b;
        #2;
        checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL idle_m1_gnt: got %b want 1", m1_gnt); end
        step();
        m1_req = 1'b0;
        #2;
        for (int i = 0; i < 10; i++) begin
            step();
            m0_addr = 10'($urandom);
            #2;
            checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin failures++; $display("FAIL idle_ctrl cycle %0d: got %b want 0000", i, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
            checks++; if ({m0_rdata, m1_rdata} !== {rom[a], rom[b]}) begin failures++; $display("FAIL idle_hold cycle %0d: got %h %h want %h %h", i, m0_rdata, m1_rdata, rom[a], rom[b]); end
            checks++; if (rom_addr !== m0_addr) begin failures++; $display("FAIL idle_rom_addr cycle %0d: got %h want %h", i, rom_addr, m0_addr); end
        end
    endtask

    task automatic test_random();
        logic g0 = 1'b0, g1 = 1'b0;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            step();
            if (g0 || !m0_req) begin
                m0_req = ($urandom % 3) != 0;
                m0_addr = 10'($urandom);
                m0_len = 2'($urandom);
            end
            if (g1 || !m1_req) begin
                m1_req = ($urandom % 3) != 0;
                m1_addr = 10'($urandom);
            end
            #2;
            model_step();
            checks++; if ({m0_gnt, m1_gnt, busy} !== {e_g0, e_g1, e_busy}) begin failures++; $display("FAIL rnd_gnt cycle %0d: got %b want %b", n, {m0_gnt, m1_gnt, busy}, {e_g0, e_g1, e_busy}); end
            checks++; if ({m0_rvalid, m0_rlast, m0_rdata} !== {e_v0, e_l0, e_d0}) begin failures++; $display("FAIL rnd_m0_resp cycle %0d: got %b %b %h want %b %b %h", n, m0_rvalid, m0_rlast, m0_rdata, e_v0, e_l0, e_d0); end
            checks++; if ({m1_rvalid, m1_rdata} !== {e_v1, e_d1}) begin failures++; $display("FAIL rnd_m1_resp cycle %0d: got %b %h want %b %h", n, m1_rvalid, m1_rdata, e_v1, e_d1); end
            g0 = m0_gnt;
            g1 = m1_gnt;
        end
        step();
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        test_reset();
        test_single();
        test_burst();
        test_alternate();
        test_m1_during_burst();
        test_reset_mid_burst();
        test_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and sequencer for the single-ported, combinational-read instruction ROM (32-bit words, 10-bit word address). It shares the ROM between requester 0 (instruction fetch, with up to 4-beat sequential bursts) and requester 1 (data/debug reads). Arbitration is round-robin. Each requester gets a registered, one-cycle-latency read response. The block sits between the CPU front end and the ROM, and it alone drives the ROM address.

## Interface
- ADDR_W, 10, word-address width; ROM depth is 2^ADDR_W
- DATA_W, 32, ROM word width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  requester 0 read request, held until m0_gnt
- m0_addr  in  ADDR_W  requester 0 start word address, stable while m0_req
- m0_len  in  2  requester 0 burst length minus 1 (0 means 1 beat, 3 means 4 beats), stable while m0_req
- m0_gnt  out  1  one-cycle pulse: request accepted this cycle
- m0_rvalid  out  1  m0_rdata valid this cycle
- m0_rdata  out  DATA_W  read data
- m0_rlast  out  1  qualifies the final beat of a burst
- m1_req  in  1  requester 1 read request, single beat only
- m1_addr  in  ADDR_W  requester 1 word address
- m1_gnt, m1_rvalid, m1_rdata  out  1/1/DATA_W  same meaning as the m0 signals
- rom_addr  out  ADDR_W  address to ROM
- rom_data  in  DATA_W  combinational ROM read data for rom_addr
- busy  out  1  burst in progress (state BURST)

## Operation
- State machine has two states:
  - IDLE: grant is decided combinationally from the requests.
  - BURST: the current owner keeps the ROM; no grants are issued.
- Arbitration in IDLE:
  - Only one requester asserting req: it is granted.
  - Both asserting req: grant the port that was not granted last (last_gnt register; updated on every grant).
- Granted address (beat 0) drives rom_addr in the grant cycle. rom_data is captured into that port's rdata at the next edge.
- Grant to m0 with m0_len > 0 moves to BURST, with owner=0, beat counter=1, base=m0_addr, len=m0_len latched.
- In BURST:
  - rom_addr = base + counter, modulo 2^ADDR_W (1023 wraps to 0).
  - Counter increments each cycle.
  - Return to IDLE after the cycle in which counter == len.
- m1 grants are always single beat and never enter BURST.
- rlast is 1 on the last beat of the transfer; for single-beat transfers it coincides with rvalid.
- rdata holds its last value when rvalid=0.
- No request pending in IDLE: rom_addr = m0_addr, and no response follows.
- Requests arriving while in BURST wait; arbitration resumes the cycle after the last burst beat's address cycle.
- Reset values, and the state forced while rst is high:
  - state=IDLE, busy=0, counter=0.
  - last_gnt=1, so m0 wins the first tie.
  - all gnt=0, rvalid=0, rlast=0, rdata=0, rom_addr=0.
- Reset asserted mid-burst aborts the burst immediately. No further rvalid is produced for that burst, and the requester must re-request.

## Timing
- Grant cycle T reads beat 0; rvalid for beat 0 is at T+1.
- A burst of N=len+1 beats reads in cycles T..T+N-1. Responses are at T+1..T+N with no gaps, and rlast is at T+N.
- busy=1 during cycles T+1..T+N-1. The next grant is possible at T+N.
- Single-beat transfers sustain back-to-back grants every cycle. Alternating m0/m1 under continuous dual requests gives 1 word per cycle total.
- The gnt path is combinational from req and state only; there is no combinational path from rom_data to any output.
- rvalid for one port and gnt for either port may coincide in the same cycle.

## Test plan
- Reset, then m0_req=1, m0_addr=0x005, m0_len=0: m0_gnt at cycle 0; m0_rvalid=1, m0_rlast=1, m0_rdata=ROM[0x005] at cycle 1; busy stays 0.
- m0 burst with addr=0x3FE, len=3: rom_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; four consecutive rvalid beats with rlast on the 4th; busy high for 3 cycles.
- m0 and m1 both requesting continuously, single beats, starting from reset: grants alternate m0, m1, m0, m1; each port gets rvalid one cycle after its gnt.
- m1_req raised during an m0 burst with len=2: m1_gnt is withheld during BURST and asserted in the cycle after the last burst address; m1_rdata equals ROM[m1_addr].
- rst pulsed during beat 1 of a 4-beat burst: outputs go to reset values asynchronously; after release, no stray rvalid, busy=0, and a new m0 request is granted normally.
- No requests for 10 cycles after traffic: all gnt and rvalid stay 0, and rdata holds its last value.
